vga_sync_rx: RTL and testbench
==============================

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640, horizontal active pixels.
REQ-002 SHALL have parameter H_TOTAL, default 800, expected pixels per line.
REQ-003 SHALL have parameter H_SYNC_START, default 656, pixel index of the first hsync-active pixel.
REQ-004 SHALL have parameter V_DISPLAY, default 480, active lines.
REQ-005 SHALL have parameter V_TOTAL, default 525, expected lines per frame.
REQ-006 SHALL have parameter V_SYNC_START, default 513, line index of the first vsync-active line.
REQ-007 SHALL have parameter SYNC_POL, default 1, sync level during retrace (1 = high, 0 = low).
REQ-008 SHALL have parameter LOCK_COUNT, default 2, consecutive good measurements required for lock (range 1..7).
REQ-009 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge except reset.
REQ-010 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-011 SHALL have port p_tick, input, 1, pixel enable; sync inputs are sampled only on clk edges where p_tick=1 ("tick").
REQ-012 SHALL have port hsync, input, 1, horizontal sync from the source.
REQ-013 SHALL have port vsync, input, 1, vertical sync from the source.
REQ-014 SHALL have port x, output, 10, recovered pixel column.
REQ-015 SHALL have port y, output, 10, recovered line number.
REQ-016 SHALL have port video_on, output, 1, recovered active-area flag.
REQ-017 SHALL have port locked, output, 1, timing lock indicator.
REQ-018 SHALL have port h_total, output, 10, last measured line length in ticks.
REQ-019 SHALL have port v_total, output, 10, last measured frame length in lines.
REQ-020 SHALL have port err, output, 1, one-clk pulse on a timing fault.

Function
REQ-021 SHALL normalise syncs as hs = hsync XNOR SYNC_POL and vs = vsync XNOR SYNC_POL, register them on each tick into hs_prev/vs_prev, and define a leading edge as hs=1 with hs_prev=0 (likewise for vs).
REQ-022 SHALL leave all state unchanged on clk edges without a tick.
REQ-023 SHALL advance x on each tick: x wraps from H_TOTAL-1 to 0, else increments; an hs leading edge loads x = H_SYNC_START+1, overriding the increment.
REQ-024 SHALL advance y on each tick where x = H_TOTAL-1: y wraps from V_TOTAL-1 to 0, else increments; a vs leading edge loads y = V_SYNC_START, overriding the increment; both loads SHALL apply when hs and vs edges coincide.
REQ-025 SHALL keep a 10-bit line-period counter: cleared on an hs edge tick, else incremented per tick, saturating at 1023.
REQ-026 SHALL, on an hs edge tick with a prior edge recorded, set h_total = counter+1 (saturating at 1023).
REQ-027 SHALL treat the first hs edge after reset or timeout as a restart only: no h_total update, no err.
REQ-028 SHALL count hs edges between vs edges with an identical saturating counter, updating v_total under the same first-edge rule.
REQ-029 SHALL keep h_good and v_good counters (0..LOCK_COUNT) that increment, saturating, on a measurement equal to H_TOTAL / V_TOTAL and clear to 0 on a mismatch.
REQ-030 SHALL drive locked = (h_good = LOCK_COUNT) AND (v_good = LOCK_COUNT), registered.
REQ-031 SHALL treat either period counter reaching 1023 as a timeout: clear its good counter, clear its prior-edge flag, pulse err once on the transition to 1023.
REQ-032 SHALL pulse err for exactly one clk on any mismatched measurement or timeout; simultaneous faults SHALL produce a single pulse.
REQ-033 SHALL drive video_on = locked AND x < H_DISPLAY AND y < V_DISPLAY, registered alongside x and y.

Reset
REQ-034 SHALL, while rst=0, force x, y, h_total, v_total, both period counters, good counters and prior-edge flags to 0, and video_on, locked and err to 0.
REQ-035 SHALL reset hs_prev and vs_prev to 1 so a sync already active at reset release is not taken as an edge.
REQ-036 SHALL take effect immediately on rst falling, including mid-line or mid-frame, and resume from the reset state on the first tick after release.

Verification
REQ-037 SHALL cover ideal 640x480 timing from the matching generator (p_tick every 4 clk, SYNC_POL=1) -> h_total=800, v_total=525, locked=1 after LOCK_COUNT+1 frames, and x/y equal to the source counters from then on.
REQ-038 SHALL cover one line shortened to 799 ticks -> err pulses once, h_total=799, locked drops, and relock occurs after 2 good lines plus any required good frames.
REQ-039 SHALL cover hsync held inactive -> err pulses at the 1023rd tick, locked=0, and the next edge is a restart with no err.
REQ-040 SHALL cover SYNC_POL=0 with inverted syncs -> identical lock, h_total and v_total results.
REQ-041 SHALL cover rst asserted mid-frame while locked -> all outputs 0 immediately, with no false edge if hsync is active at release.
REQ-042 SHALL cover p_tick held at 0 for 100 clk while locked -> x, y and the counters frozen, with no err.

Source files
------------

// File: rtl/vga_sync_rx_if.sv
// Signal bundle between a VGA-style timing source and the sync recovery block.
interface vga_sync_rx_if;
   logic       p_tick;
   logic       hsync;
   logic       vsync;
   logic [9:0] x;
   logic [9:0] y;
   logic       video_on;
   logic       locked;
   logic [9:0] h_total;
   logic [9:0] v_total;
   logic       err;

   modport master (
      output p_tick, hsync, vsync,
      input  x, y, video_on, locked, h_total, v_total, err
   );

   modport slave (
      input  p_tick, hsync, vsync,
      output x, y, video_on, locked, h_total, v_total, err
   );
endinterface

// File: rtl/vga_sync_rx.sv
// Recovers pixel column/line position from hsync/vsync, measures line and frame
// periods, and reports lock once both periods repeatedly match the expected timing.
module vga_sync_rx #(
   parameter int H_DISPLAY    = 640,
   parameter int H_TOTAL      = 800,
   parameter int H_SYNC_START = 656,
   parameter int V_DISPLAY    = 480,
   parameter int V_TOTAL      = 525,
   parameter int V_SYNC_START = 513,
   parameter int SYNC_POL     = 1,
   parameter int LOCK_COUNT   = 2
) (
   input logic          clk,
   input logic          rst,
   vga_sync_rx_if.slave bus
);

   localparam logic [9:0] CNT_MAX  = 10'd1023;
   localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] X_LOAD   = 10'(H_SYNC_START + 1);
   localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] Y_LOAD   = 10'(V_SYNC_START);
   localparam logic [9:0] H_EXP    = 10'(H_TOTAL);
   localparam logic [9:0] V_EXP    = 10'(V_TOTAL);
   localparam logic [9:0] X_ACT    = 10'(H_DISPLAY);
   localparam logic [9:0] Y_ACT    = 10'(V_DISPLAY);
   localparam logic [2:0] GOOD_MAX = 3'(LOCK_COUNT);
   localparam logic       POL      = (SYNC_POL != 0);

   logic       hs, vs, hs_edge, vs_edge;
   logic       hs_prev, vs_prev;
   logic [9:0] x_q, x_nxt;
   logic [9:0] y_q, y_nxt;
   logic [9:0] h_cnt, h_cnt_nxt;
   logic [9:0] v_cnt, v_cnt_nxt;
   logic [9:0] h_tot_q, h_tot_nxt;
   logic [9:0] v_tot_q, v_tot_nxt;
   logic [9:0] h_meas, v_meas;
   logic       h_seen, h_seen_nxt;
   logic       v_seen, v_seen_nxt;
   logic [2:0] h_good, h_good_nxt;
   logic [2:0] v_good, v_good_nxt;
   logic       h_fault, v_fault;
   logic       locked_q, locked_nxt;
   logic       video_q, video_nxt;
   logic       err_q;

   assign hs      = ~(bus.hsync ^ POL);
   assign vs      = ~(bus.vsync ^ POL);
   assign hs_edge = hs & ~hs_prev;
   assign vs_edge = vs & ~vs_prev;

   assign h_meas = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 10'd1;
   // An hs edge on the vs edge tick still belongs to the frame being closed.
   assign v_meas = (hs_edge && (v_cnt != CNT_MAX)) ? v_cnt + 10'd1 : v_cnt;

   always_comb begin
      x_nxt = x_q + 10'd1;
      if (x_q == X_LAST) x_nxt = 10'd0;
      if (hs_edge)       x_nxt = X_LOAD;

      y_nxt = y_q;
      if (x_q == X_LAST) y_nxt = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
      if (vs_edge)       y_nxt = Y_LOAD;
   end

   always_comb begin
      h_cnt_nxt  = h_cnt;
      h_seen_nxt = h_seen;
      h_good_nxt = h_good;
      h_tot_nxt  = h_tot_q;
      h_fault    = 1'b0;
      if (hs_edge) begin
         h_cnt_nxt  = 10'd0;
         h_seen_nxt = 1'b1;
         if (h_seen) begin
            h_tot_nxt = h_meas;
            if (h_meas == H_EXP) begin
               h_good_nxt = (h_good == GOOD_MAX) ? h_good : h_good + 3'd1;
            end else begin
               h_good_nxt = 3'd0;
               h_fault    = 1'b1;
            end
         end
      end else if (h_cnt != CNT_MAX) begin
         h_cnt_nxt = h_cnt + 10'd1;
         if (h_cnt == CNT_MAX - 10'd1) begin
            h_seen_nxt = 1'b0;
            h_good_nxt = 3'd0;
            h_fault    = 1'b1;
         end
      end
   end

   always_comb begin
      v_cnt_nxt  = v_cnt;
      v_seen_nxt = v_seen;
      v_good_nxt = v_good;
      v_tot_nxt  = v_tot_q;
      v_fault    = 1'b0;
      if (vs_edge) begin
         v_cnt_nxt  = 10'd0;
         v_seen_nxt = 1'b1;
         if (v_seen) begin
            v_tot_nxt = v_meas;
            if (v_meas == V_EXP) begin
               v_good_nxt = (v_good == GOOD_MAX) ? v_good : v_good + 3'd1;
            end else begin
               v_good_nxt = 3'd0;
               v_fault    = 1'b1;
            end
         end
      end else if (hs_edge && (v_cnt != CNT_MAX)) begin
         v_cnt_nxt = v_cnt + 10'd1;
         if (v_cnt == CNT_MAX - 10'd1) begin
            v_seen_nxt = 1'b0;
            v_good_nxt = 3'd0;
            v_fault    = 1'b1;
         end
      end
   end

   always_comb begin
      locked_nxt = (h_good_nxt == GOOD_MAX) && (v_good_nxt == GOOD_MAX);
      video_nxt  = locked_nxt && (x_nxt < X_ACT) && (y_nxt < Y_ACT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hs_prev  <= 1'b1;
         vs_prev  <= 1'b1;
         x_q      <= 10'd0;
         y_q      <= 10'd0;
         h_cnt    <= 10'd0;
         v_cnt    <= 10'd0;
         h_tot_q  <= 10'd0;
         v_tot_q  <= 10'd0;
         h_seen   <= 1'b0;
         v_seen   <= 1'b0;
         h_good   <= 3'd0;
         v_good   <= 3'd0;
         locked_q <= 1'b0;
         video_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (bus.p_tick) begin
            hs_prev  <= hs;
            vs_prev  <= vs;
            x_q      <= x_nxt;
            y_q      <= y_nxt;
            h_cnt    <= h_cnt_nxt;
            v_cnt    <= v_cnt_nxt;
            h_tot_q  <= h_tot_nxt;
            v_tot_q  <= v_tot_nxt;
            h_seen   <= h_seen_nxt;
            v_seen   <= v_seen_nxt;
            h_good   <= h_good_nxt;
            v_good   <= v_good_nxt;
            locked_q <= locked_nxt;
            video_q  <= video_nxt;
            err_q    <= h_fault | v_fault;
         end
      end
   end

   assign bus.x        = x_q;
   assign bus.y        = y_q;
   assign bus.video_on = video_q;
   assign bus.locked   = locked_q;
   assign bus.h_total  = h_tot_q;
   assign bus.v_total  = v_tot_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Scoreboard bench for vga_sync_rx: a timing source with injected faults drives two
// instances (high and low sync polarity) checked against a tick-index reference model.
module tb_vga_sync_rx;

   localparam int H_DISPLAY    = 16;
   localparam int H_TOTAL      = 24;
   localparam int H_SYNC_START = 18;
   localparam int HS_W         = 3;
   localparam int V_DISPLAY    = 8;
   localparam int V_TOTAL      = 12;
   localparam int V_SYNC_START = 9;
   localparam int VS_W         = 2;
   localparam int LC           = 2;
   localparam int FRAME        = H_TOTAL * V_TOTAL;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [9:0] h_total;
      logic [9:0] v_total;
      logic       video_on;
      logic       locked;
      logic       err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   vga_sync_rx_if bus_p ();
   vga_sync_rx_if bus_n ();

   vga_sync_rx #(
      .H_DISPLAY(H_DISPLAY), .H_TOTAL(H_TOTAL), .H_SYNC_START(H_SYNC_START),
      .V_DISPLAY(V_DISPLAY), .V_TOTAL(V_TOTAL), .V_SYNC_START(V_SYNC_START),
      .SYNC_POL(1), .LOCK_COUNT(LC)
   ) dut_p (.clk(clk), .rst(rst), .bus(bus_p.slave));

   vga_sync_rx #(
      .H_DISPLAY(H_DISPLAY), .H_TOTAL(H_TOTAL), .H_SYNC_START(H_SYNC_START),
      .V_DISPLAY(V_DISPLAY), .V_TOTAL(V_TOTAL), .V_SYNC_START(V_SYNC_START),
      .SYNC_POL(0), .LOCK_COUNT(LC)
   ) dut_n (.clk(clk), .rst(rst), .bus(bus_n.slave));

   int   n_checks = 0;
   int   n_fail   = 0;
   int   err_cnt  = 0;
   exp_t exp_q[$];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: periods from absolute tick indices, position from the last load point.
   int m_t, h_ref, h_good, lines, v_good, x_base, x_base_t, m_y, m_htot, m_vtot;
   bit h_seen, v_seen, hs_p, vs_p;

   function automatic int clamp(input int v);
      return (v > 1023) ? 1023 : v;
   endfunction

   task automatic model_reset();
      m_t = 0; h_ref = -1; h_seen = 0; h_good = 0;
      lines = 0; v_seen = 0; v_good = 0;
      x_base = 0; x_base_t = -1; m_y = 0; m_htot = 0; m_vtot = 0;
      hs_p = 1; vs_p = 1;
   endtask

   task automatic model_tick(input bit hs, input bit vs, output exp_t e);
      bit he, ve, fault;
      int x_before, x_now, meas;
      he = hs && !hs_p;
      ve = vs && !vs_p;
      fault = 0;
      x_before = (x_base + (m_t - 1 - x_base_t)) % H_TOTAL;
      if (he) begin
         if (h_seen) begin
            m_htot = clamp(m_t - h_ref);
            if (m_htot == H_TOTAL) h_good = (h_good < LC) ? h_good + 1 : LC;
            else begin h_good = 0; fault = 1; end
         end
         h_seen = 1;
         h_ref  = m_t;
      end else if (m_t - h_ref == 1023) begin
         h_seen = 0; h_good = 0; fault = 1;
      end
      if (ve) begin
         if (v_seen) begin
            meas   = clamp(lines + (he ? 1 : 0));
            m_vtot = meas;
            if (meas == V_TOTAL) v_good = (v_good < LC) ? v_good + 1 : LC;
            else begin v_good = 0; fault = 1; end
         end
         v_seen = 1;
         lines  = 0;
      end else if (he && lines < 1023) begin
         lines++;
         if (lines == 1023) begin v_seen = 0; v_good = 0; fault = 1; end
      end
      if (he) begin x_base = H_SYNC_START + 1; x_base_t = m_t; end
      if (ve) m_y = V_SYNC_START;
      else if (x_before == H_TOTAL - 1) m_y = (m_y + 1) % V_TOTAL;
      x_now = (x_base + (m_t - x_base_t)) % H_TOTAL;
      e.x        = 10'(x_now);
      e.y        = 10'(m_y);
      e.h_total  = 10'(m_htot);
      e.v_total  = 10'(m_vtot);
      e.locked   = (h_good == LC) && (v_good == LC);
      e.video_on = e.locked && (x_now < H_DISPLAY) && (m_y < V_DISPLAY);
      e.err      = fault;
      hs_p = hs; vs_p = vs;
      m_t++;
   endtask

   // Timing source with injectable short line and hsync dropout.
   int hc = 0, vc = 0, drop_left = 0;
   bit short_pend = 0;

   task automatic present(output bit hs, output bit vs);
      hs = (hc >= H_SYNC_START) && (hc < H_SYNC_START + HS_W) && (drop_left == 0);
      vs = (vc >= V_SYNC_START) && (vc < V_SYNC_START + VS_W);
      if (drop_left > 0) drop_left--;
      hc++;
      if (hc == H_TOTAL - (short_pend ? 1 : 0)) begin
         hc = 0; short_pend = 0; vc = (vc + 1) % V_TOTAL;
      end
   endtask

   task automatic clock_step(input bit do_tick);
      bit   hs, vs;
      exp_t e;
      if (do_tick) begin
         present(hs, vs);
         model_tick(hs, vs, e);
         exp_q.push_back(e);
         bus_p.hsync = hs;  bus_p.vsync = vs;
         bus_n.hsync = !hs; bus_n.vsync = !vs;
      end else begin
         bus_p.hsync = 1'($urandom_range(0, 1)); bus_p.vsync = 1'($urandom_range(0, 1));
         bus_n.hsync = 1'($urandom_range(0, 1)); bus_n.vsync = 1'($urandom_range(0, 1));
      end
      bus_p.p_tick = do_tick;
      bus_n.p_tick = do_tick;
      @(posedge clk);
      #2;
   endtask

   task automatic tick1();
      repeat ($urandom_range(0, 3)) clock_step(1'b0);
      clock_step(1'b1);
   endtask

   task automatic run_ticks(input int n);
      repeat (n) tick1();
   endtask

   task automatic tick_until_hc(input int target);
      for (int i = 0; i < 4 * H_TOTAL && hc != target; i++) tick1();
   endtask

   function automatic exp_t snap_p();
      exp_t s;
      s.x = bus_p.x; s.y = bus_p.y; s.h_total = bus_p.h_total; s.v_total = bus_p.v_total;
      s.video_on = bus_p.video_on; s.locked = bus_p.locked; s.err = bus_p.err;
      return s;
   endfunction

   function automatic exp_t snap_n();
      exp_t s;
      s.x = bus_n.x; s.y = bus_n.y; s.h_total = bus_n.h_total; s.v_total = bus_n.v_total;
      s.video_on = bus_n.video_on; s.locked = bus_n.locked; s.err = bus_n.err;
      return s;
   endfunction

   task automatic cmp_rec(input string tag, input exp_t a, input exp_t e);
      chk({tag, "_x"},        int'(a.x),        int'(e.x));
      chk({tag, "_y"},        int'(a.y),        int'(e.y));
      chk({tag, "_h_total"},  int'(a.h_total),  int'(e.h_total));
      chk({tag, "_v_total"},  int'(a.v_total),  int'(e.v_total));
      chk({tag, "_video_on"}, int'(a.video_on), int'(e.video_on));
      chk({tag, "_locked"},   int'(a.locked),   int'(e.locked));
      chk({tag, "_err"},      int'(a.err),      int'(e.err));
   endtask

   // Monitor: pops one expectation per tick edge, otherwise everything must hold and err be low.
   initial begin
      exp_t last_exp, e, hold;
      bit   tick_seen;
      last_exp = '0;
      forever begin
         @(posedge clk);
         tick_seen = bus_p.p_tick;
         @(negedge clk);
         if (!rst) begin
            last_exp = '0;
            cmp_rec("reset_p", snap_p(), last_exp);
            cmp_rec("reset_n", snap_n(), last_exp);
         end else if (tick_seen) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL queue_empty: actual=0 entries expected>=1 at t=%0t", $time);
            end else begin
               e = exp_q.pop_front();
               cmp_rec("tick_p", snap_p(), e);
               cmp_rec("tick_n", snap_n(), e);
               last_exp = e;
               if (bus_p.err) err_cnt++;
            end
         end else begin
            hold = last_exp;
            hold.err = 1'b0;
            cmp_rec("hold_p", snap_p(), hold);
            cmp_rec("hold_n", snap_n(), hold);
         end
      end
   end

   initial begin
      #600000;
      n_fail++;
      $display("FAIL watchdog: actual=timeout expected=finish at t=%0t", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e0, hstart;
      bus_p.p_tick = 1'b0; bus_p.hsync = 1'b0; bus_p.vsync = 1'b0;
      bus_n.p_tick = 1'b0; bus_n.hsync = 1'b1; bus_n.vsync = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;

      // Ideal timing: lock within LC+1 frames, position tracks the source.
      run_ticks(4 * FRAME);
      chk("ideal_locked_p", int'(bus_p.locked), 1);
      chk("ideal_locked_n", int'(bus_n.locked), 1);
      chk("ideal_h_total", int'(bus_p.h_total), H_TOTAL);
      chk("ideal_v_total", int'(bus_p.v_total), V_TOTAL);
      chk("ideal_h_total_n", int'(bus_n.h_total), H_TOTAL);
      chk("ideal_v_total_n", int'(bus_n.v_total), V_TOTAL);
      chk("ideal_x_src", int'(bus_p.x), hc);
      chk("ideal_y_src", int'(bus_p.y), vc);

      // One line a tick short.
      run_ticks($urandom_range(0, FRAME - 1));
      tick_until_hc(0);
      e0 = err_cnt;
      short_pend = 1;
      run_ticks(H_TOTAL - 1 + H_SYNC_START + 1);
      chk("short_h_total", int'(bus_p.h_total), H_TOTAL - 1);
      chk("short_unlocked", int'(bus_p.locked), 0);
      run_ticks(H_TOTAL);
      chk("short_one_good_line", int'(bus_p.locked), 0);
      run_ticks(H_TOTAL);
      chk("short_relocked", int'(bus_p.locked), 1);
      chk("short_err_pulses", err_cnt - e0, 1);

      // hsync held inactive long enough to time out the line counter.
      tick_until_hc(H_SYNC_START + 1);
      drop_left = 1100 + H_TOTAL * $urandom_range(0, 2);
      run_ticks(1022);
      tick1();
      chk("timeout_err", int'(bus_p.err), 1);
      chk("timeout_unlocked", int'(bus_p.locked), 0);
      for (int i = 0; i < 200 && !(drop_left == 0 && hc == H_SYNC_START + 1); i++) tick1();
      chk("restart_err", int'(bus_p.err), 0);
      chk("restart_h_total", int'(bus_p.h_total), H_TOTAL);
      run_ticks(4 * FRAME);
      chk("relock_after_timeout", int'(bus_p.locked), 1);

      // Tick stream paused while locked: the monitor checks every frozen cycle.
      repeat (100) clock_step(1'b0);
      run_ticks(H_TOTAL);
      chk("freeze_locked", int'(bus_p.locked), 1);

      // Reset mid-frame, released with hsync already active.
      run_ticks($urandom_range(0, FRAME - 1));
      tick_until_hc(H_SYNC_START);
      clock_step(1'b0);
      #1 rst = 1'b0;
      model_reset();
      #1;
      chk("rst_x", int'(bus_p.x), 0);
      chk("rst_locked", int'(bus_p.locked), 0);
      chk("rst_h_total", int'(bus_p.h_total), 0);
      chk("rst_video_on", int'(bus_n.video_on), 0);
      hstart = 3 + $urandom_range(0, 3);
      repeat (hstart) clock_step(1'b0);
      #1 rst = 1'b1;
      clock_step(1'b1);
      chk("rst_no_edge_x", int'(bus_p.x), 1);
      chk("rst_no_edge_x_n", int'(bus_n.x), 1);
      run_ticks(4 * FRAME);
      chk("post_rst_locked", int'(bus_p.locked), 1);
      chk("post_rst_locked_n", int'(bus_n.locked), 1);
      chk("post_rst_v_total", int'(bus_n.v_total), V_TOTAL);
      chk("post_rst_x_src", int'(bus_p.x), hc);
      chk("post_rst_y_src", int'(bus_p.y), vc);

      repeat (2) clock_step(1'b0);
      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
